// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: funct3 values, FSM states, write-back actions,
// byte-enable patterns and the access legality check.
package mem_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic {IDLE, WAIT} state_t;

    typedef enum logic [1:0] {WB_PASS, WB_BUBBLE, WB_FAULT, WB_DONE} wb_op_t;

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic access_illegal(input logic rd, input logic wr,
                                            input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = rd && wr;
        if (rd && !(f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU))
            bad = 1'b1;
        if (wr && !(f3 == F3_SB || f3 == F3_SH || f3 == F3_SW))
            bad = 1'b1;
        if ((rd || wr) && f3[1:0] == 2'b01 && off[0])
            bad = 1'b1;
        if ((rd || wr) && f3[1:0] == 2'b10 && off != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store byte enables / replicated write data, and load lane
// extraction with sign or zero extension.
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = rdata[{offset, 3'b000} +: 8];
        lane_half = offset[1] ? rdata[31:16] : rdata[15:0];
        be        = BE_WORD;
        wdata     = store_data;
        load_data = rdata;
        case (funct3[1:0])
            2'b00: begin
                be        = BE_BYTE << offset;
                wdata     = {4{store_data[7:0]}};
                load_data = funct3[2] ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            end
            2'b01: begin
                be        = BE_HALF << {offset[1], 1'b0};
                wdata     = {2{store_data[15:0]}};
                load_data = funct3[2] ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32 MEM stage: issues one data-memory access at a time over a req/ready handshake,
// stalls upstream while it is outstanding, and registers the write-back bundle.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 mem_read_mem,
    input  logic                 mem_write_mem,
    input  logic [2:0]           inst_14_to_12_mem,
    input  logic [DATA_SIZE-1:0] address_alu_result_mem,
    input  logic [DATA_SIZE-1:0] read_data_2_mem,
    input  logic                 reg_write_mem,
    input  logic [1:0]           mem_to_reg_mem,
    input  logic [4:0]           inst_11_to_7_mem,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_SIZE-1:0] dmem_addr,
    output logic [3:0]           dmem_be,
    output logic [DATA_SIZE-1:0] dmem_wdata,
    input  logic [DATA_SIZE-1:0] dmem_rdata,
    input  logic                 dmem_ready,
    output logic                 stall,
    output logic                 reg_write_wb,
    output logic [1:0]           mem_to_reg_wb,
    output logic [4:0]           inst_11_to_7_wb,
    output logic [DATA_SIZE-1:0] alu_result_wb,
    output logic [DATA_SIZE-1:0] load_data_wb,
    output logic                 access_fault_wb
);

    state_t state, state_next;
    wb_op_t wb_op;
    logic   mem_op, illegal, capture;

    logic [2:0]  req_funct3;
    logic [1:0]  req_offset;
    logic [2:0]  align_funct3;
    logic [1:0]  align_offset;
    logic [3:0]  align_be;
    logic [31:0] align_wdata, align_load;

    assign mem_op  = mem_read_mem | mem_write_mem;
    assign illegal = access_illegal(mem_read_mem, mem_write_mem, inst_14_to_12_mem,
                                    address_alu_result_mem[1:0]);

    // The aligner serves the incoming op in IDLE and the held request in WAIT.
    assign align_funct3 = (state == WAIT) ? req_funct3 : inst_14_to_12_mem;
    assign align_offset = (state == WAIT) ? req_offset : address_alu_result_mem[1:0];

    lsu_align u_align (
        .funct3     (align_funct3),
        .offset     (align_offset),
        .store_data (read_data_2_mem),
        .rdata      (dmem_rdata),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_data  (align_load)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        capture    = 1'b0;
        wb_op      = WB_PASS;
        case (state)
            IDLE: begin
                if (mem_op && illegal) begin
                    wb_op = WB_FAULT;
                end else if (mem_op) begin
                    capture    = 1'b1;
                    stall      = 1'b1;
                    wb_op      = WB_BUBBLE;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (dmem_ready) begin
                    wb_op      = WB_DONE;
                    state_next = IDLE;
                end else begin
                    stall = 1'b1;
                    wb_op = WB_BUBBLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (clear) stall = 1'b0;
    end

    assign dmem_req = (state == WAIT) && !clear;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            req_funct3 <= '0;
            req_offset <= '0;
        end else if (capture) begin
            dmem_we    <= mem_write_mem;
            dmem_addr  <= address_alu_result_mem[ADDR_SIZE+1:2];
            dmem_be    <= align_be;
            dmem_wdata <= align_wdata;
            req_funct3 <= inst_14_to_12_mem;
            req_offset <= address_alu_result_mem[1:0];
        end
    end

    // Write-back boundary: EX/MEM fields are held by stall, so they are still valid on completion.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            reg_write_wb    <= 1'b0;
            mem_to_reg_wb   <= '0;
            inst_11_to_7_wb <= '0;
            alu_result_wb   <= '0;
            load_data_wb    <= '0;
            access_fault_wb <= 1'b0;
        end else begin
            reg_write_wb    <= reg_write_mem &&
                               (wb_op == WB_PASS || (wb_op == WB_DONE && !dmem_we));
            mem_to_reg_wb   <= mem_to_reg_mem;
            inst_11_to_7_wb <= inst_11_to_7_mem;
            alu_result_wb   <= address_alu_result_mem;
            load_data_wb    <= (wb_op == WB_DONE && !dmem_we) ? align_load : '0;
            access_fault_wb <= (wb_op == WB_FAULT);
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Table-driven bench for mem_access_stage with a write-back scoreboard and
// hand-written reset / clear-during-access sequences.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        clear;
    logic        mem_read_mem, mem_write_mem;
    logic [2:0]  inst_14_to_12_mem;
    logic [31:0] address_alu_result_mem, read_data_2_mem;
    logic        reg_write_mem;
    logic [1:0]  mem_to_reg_mem;
    logic [4:0]  inst_11_to_7_mem;
    logic        dmem_req, dmem_we;
    logic [9:0]  dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_ready, stall;
    logic        reg_write_wb;
    logic [1:0]  mem_to_reg_wb;
    logic [4:0]  inst_11_to_7_wb;
    logic [31:0] alu_result_wb, load_data_wb;
    logic        access_fault_wb;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.DATA_SIZE(32), .ADDR_SIZE(10)) dut (
        .clk                    (clk),
        .clear                  (clear),
        .mem_read_mem           (mem_read_mem),
        .mem_write_mem          (mem_write_mem),
        .inst_14_to_12_mem      (inst_14_to_12_mem),
        .address_alu_result_mem (address_alu_result_mem),
        .read_data_2_mem        (read_data_2_mem),
        .reg_write_mem          (reg_write_mem),
        .mem_to_reg_mem         (mem_to_reg_mem),
        .inst_11_to_7_mem       (inst_11_to_7_mem),
        .dmem_req               (dmem_req),
        .dmem_we                (dmem_we),
        .dmem_addr              (dmem_addr),
        .dmem_be                (dmem_be),
        .dmem_wdata             (dmem_wdata),
        .dmem_rdata             (dmem_rdata),
        .dmem_ready             (dmem_ready),
        .stall                  (stall),
        .reg_write_wb           (reg_write_wb),
        .mem_to_reg_wb          (mem_to_reg_wb),
        .inst_11_to_7_wb        (inst_11_to_7_wb),
        .alu_result_wb          (alu_result_wb),
        .load_data_wb           (load_data_wb),
        .access_fault_wb        (access_fault_wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, rdata;
        logic        rw;
        int          waits;
        logic        issue;
        logic [9:0]  e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_fault, e_rw;
        logic [31:0] e_load;
    } vec_t;

    typedef struct packed {
        logic        rw;
        logic [1:0]  m2r;
        logic [4:0]  rdi;
        logic [31:0] alu;
        logic [31:0] load;
        logic        fault;
    } wb_t;

    localparam int NVEC = 18;
    vec_t tbl[NVEC];
    wb_t  sb[$];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] rdata, input logic rw, input int waits,
                                input logic [9:0] e_addr, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic e_fault,
                                input logic e_rw, input logic [31:0] e_load);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.rw = rw; v.waits = waits; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
        v.e_fault = e_fault; v.e_rw = e_rw; v.e_load = e_load;
        v.issue = (rd || wr) && !e_fault;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive_nop();
        mem_read_mem = 1'b0; mem_write_mem = 1'b0; inst_14_to_12_mem = 3'b000;
        address_alu_result_mem = 32'h0; read_data_2_mem = 32'h0; reg_write_mem = 1'b0;
        mem_to_reg_mem = 2'b00; inst_11_to_7_mem = 5'd0; dmem_rdata = 32'h0; dmem_ready = 1'b0;
    endtask

    task automatic run_op(input int i);
        vec_t v;
        wb_t  e, got;
        int   stalls;
        v = tbl[i];
        mem_read_mem = v.rd; mem_write_mem = v.wr; inst_14_to_12_mem = v.f3;
        address_alu_result_mem = v.addr; read_data_2_mem = v.sdata; reg_write_mem = v.rw;
        mem_to_reg_mem = 2'(i); inst_11_to_7_mem = 5'(i + 1); dmem_rdata = v.rdata;
        dmem_ready = (v.waits == 0);
        e.rw = v.e_rw; e.m2r = 2'(i); e.rdi = 5'(i + 1); e.alu = v.addr;
        e.load = v.e_load; e.fault = v.e_fault;
        sb.push_back(e);
        stalls = 0;
        @(negedge clk);
        chk("idle_req", i, 32'(dmem_req), 32'd0);
        if (stall) stalls++;
        if (v.issue) begin
            for (int c = 0; c <= v.waits; c++) begin
                @(posedge clk); #1;
                dmem_ready = (c == v.waits);
                @(negedge clk);
                if (stall) stalls++;
                chk("req", i, 32'(dmem_req), 32'd1);
                chk("addr", i, 32'(dmem_addr), 32'(v.e_addr));
                chk("we", i, 32'(dmem_we), 32'(v.wr));
                if (v.wr) begin
                    chk("be", i, 32'(dmem_be), 32'(v.e_be));
                    chk("wdata", i, dmem_wdata, v.e_wdata);
                end
            end
        end
        @(posedge clk); #1;
        mem_read_mem = 1'b0; mem_write_mem = 1'b0; dmem_ready = 1'b0;
        chk("stall_cycles", i, 32'(stalls), v.issue ? 32'(1 + v.waits) : 32'd0);
        got = {reg_write_wb, mem_to_reg_wb, inst_11_to_7_wb, alu_result_wb, load_data_wb,
               access_fault_wb};
        if (sb.size() == 0) begin
            chk("sb_empty", i, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("reg_write_wb", i, 32'(got.rw), 32'(e.rw));
            chk("mem_to_reg_wb", i, 32'(got.m2r), 32'(e.m2r));
            chk("rd_wb", i, 32'(got.rdi), 32'(e.rdi));
            chk("alu_result_wb", i, got.alu, e.alu);
            chk("load_data_wb", i, got.load, e.load);
            chk("fault_wb", i, 32'(got.fault), 32'(e.fault));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        //          rd  wr  f3      addr          sdata         rdata         rw  w  e_addr  be    e_wdata       flt e_rw e_load
        tbl[0]  = mk(0, 1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h0,        1, 2, 10'h4,  4'hF, 32'hDEADBEEF, 0, 0, 32'h0);
        tbl[1]  = mk(1, 0, 3'b000, 32'h13,       32'h0,        32'h80FFFF12, 1, 0, 10'h4,  4'h0, 32'h0,        0, 1, 32'hFFFFFF80);
        tbl[2]  = mk(1, 0, 3'b100, 32'h13,       32'h0,        32'h80FFFF12, 1, 1, 10'h4,  4'h0, 32'h0,        0, 1, 32'h00000080);
        tbl[3]  = mk(1, 0, 3'b001, 32'h22,       32'h0,        32'h80010000, 1, 1, 10'h8,  4'h0, 32'h0,        0, 1, 32'hFFFF8001);
        tbl[4]  = mk(1, 0, 3'b101, 32'h22,       32'h0,        32'h80010000, 1, 0, 10'h8,  4'h0, 32'h0,        0, 1, 32'h00008001);
        tbl[5]  = mk(1, 0, 3'b010, 32'h06,       32'h0,        32'h0,        1, 0, 10'h0,  4'h0, 32'h0,        1, 0, 32'h0);
        tbl[6]  = mk(0, 0, 3'b000, 32'h55,       32'h0,        32'h0,        1, 0, 10'h0,  4'h0, 32'h0,        0, 1, 32'h0);
        tbl[7]  = mk(0, 1, 3'b000, 32'h11,       32'h123456A5, 32'h0,        1, 0, 10'h4,  4'h2, 32'hA5A5A5A5, 0, 0, 32'h0);
        tbl[8]  = mk(0, 1, 3'b001, 32'h12,       32'h0000BEEF, 32'h0,        0, 1, 10'h4,  4'hC, 32'hBEEFBEEF, 0, 0, 32'h0);
        tbl[9]  = mk(1, 0, 3'b010, 32'h20,       32'h0,        32'h12345678, 1, 3, 10'h8,  4'h0, 32'h0,        0, 1, 32'h12345678);
        tbl[10] = mk(1, 0, 3'b011, 32'h0,        32'h0,        32'h0,        1, 0, 10'h0,  4'h0, 32'h0,        1, 0, 32'h0);
        tbl[11] = mk(0, 1, 3'b100, 32'h0,        32'h0,        32'h0,        1, 0, 10'h0,  4'h0, 32'h0,        1, 0, 32'h0);
        tbl[12] = mk(1, 1, 3'b010, 32'h0,        32'h0,        32'h0,        1, 0, 10'h0,  4'h0, 32'h0,        1, 0, 32'h0);
        tbl[13] = mk(0, 1, 3'b001, 32'h13,       32'h0,        32'h0,        1, 0, 10'h0,  4'h0, 32'h0,        1, 0, 32'h0);
        tbl[14] = mk(1, 0, 3'b001, 32'h21,       32'h0,        32'h0,        1, 0, 10'h0,  4'h0, 32'h0,        1, 0, 32'h0);
        tbl[15] = mk(1, 0, 3'b010, 32'h1FFC,     32'h0,        32'hCAFEF00D, 1, 0, 10'h3FF, 4'h0, 32'h0,       0, 1, 32'hCAFEF00D);
        tbl[16] = mk(1, 0, 3'b000, 32'h0,        32'h0,        32'h0000007F, 1, 0, 10'h0,  4'h0, 32'h0,        0, 1, 32'h0000007F);
        tbl[17] = mk(0, 0, 3'b000, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 0, 10'h0,  4'h0, 32'h0,        0, 0, 32'h0);

        // Reset with a legal load pending: everything must read zero.
        drive_nop();
        clear = 1'b1;
        mem_read_mem = 1'b1; inst_14_to_12_mem = 3'b010; address_alu_result_mem = 32'h20;
        reg_write_mem = 1'b1; dmem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 0, 32'(dmem_req), 32'd0);
        chk("rst_stall", 0, 32'(stall), 32'd0);
        chk("rst_we", 0, 32'(dmem_we), 32'd0);
        chk("rst_addr", 0, 32'(dmem_addr), 32'd0);
        chk("rst_be", 0, 32'(dmem_be), 32'd0);
        chk("rst_reg_write_wb", 0, 32'(reg_write_wb), 32'd0);
        chk("rst_alu_result_wb", 0, alu_result_wb, 32'd0);
        chk("rst_load_data_wb", 0, load_data_wb, 32'd0);
        chk("rst_fault_wb", 0, 32'(access_fault_wb), 32'd0);
        drive_nop();
        @(posedge clk); #1;
        clear = 1'b0;

        for (int i = 0; i < NVEC; i++) run_op(i);

        // Clear while an access is outstanding abandons it immediately.
        drive_nop();
        mem_read_mem = 1'b1; inst_14_to_12_mem = 3'b010; address_alu_result_mem = 32'h24;
        reg_write_mem = 1'b1; mem_to_reg_mem = 2'b01; inst_11_to_7_mem = 5'd9;
        @(posedge clk); #1;
        @(negedge clk);
        chk("clr_pre_req", 0, 32'(dmem_req), 32'd1);
        chk("clr_pre_stall", 0, 32'(stall), 32'd1);
        #2;
        clear = 1'b1;
        #1;
        chk("clr_req", 0, 32'(dmem_req), 32'd0);
        chk("clr_stall", 0, 32'(stall), 32'd0);
        chk("clr_reg_write_wb", 0, 32'(reg_write_wb), 32'd0);
        chk("clr_mem_to_reg_wb", 0, 32'(mem_to_reg_wb), 32'd0);
        chk("clr_rd_wb", 0, 32'(inst_11_to_7_wb), 32'd0);
        chk("clr_alu_result_wb", 0, alu_result_wb, 32'd0);
        chk("clr_load_data_wb", 0, load_data_wb, 32'd0);
        chk("clr_fault_wb", 0, 32'(access_fault_wb), 32'd0);
        @(posedge clk); #1;
        drive_nop();
        address_alu_result_mem = 32'h77; reg_write_mem = 1'b1; dmem_ready = 1'b1;
        clear = 1'b0;
        @(negedge clk);
        chk("post_clr_req", 0, 32'(dmem_req), 32'd0);
        chk("post_clr_stall", 0, 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("post_clr_alu", 0, alu_result_wb, 32'h77);
        chk("post_clr_reg_write", 0, 32'(reg_write_wb), 32'd1);
        chk("post_clr_req2", 0, 32'(dmem_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
